// File: rtl/color_pkg.sv
// Shared definitions for the colour-adjust pipeline: mode encodings, luma weights, default widths.
package color_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_OFFSET = 2'd1,
    MODE_GAIN   = 2'd2,
    MODE_GREY   = 2'd3
  } mode_e;

  // BT.601-style luma weights scaled by 2^LUMA_SHIFT; they sum to 256 so white maps to white.
  localparam int unsigned LUMA_R     = 77;
  localparam int unsigned LUMA_G     = 150;
  localparam int unsigned LUMA_B     = 29;
  localparam int unsigned LUMA_SHIFT = 8;

  localparam int unsigned DEF_COORD_W   = 10;
  localparam int unsigned DEF_COLOR_W   = 8;
  localparam int unsigned DEF_GAIN_W    = 8;
  localparam int unsigned DEF_GAIN_FRAC = 4;
  localparam int unsigned DEF_OFS_W     = 9;

endpackage

// File: rtl/color_sat_add.sv
// Adds a signed offset to an unsigned channel product and clamps to [0, 2^COLOR_W-1].
module color_sat_add #(
  parameter int unsigned P_W     = 12,
  parameter int unsigned OFS_W   = 9,
  parameter int unsigned COLOR_W = 8
) (
  input  logic [P_W-1:0]     p_i,
  input  logic [OFS_W-1:0]   ofs_i,
  output logic [COLOR_W-1:0] sum_o,
  output logic               clip_o
);

  // Two guard bits keep the sum free of overflow for any product/offset pair.
  localparam int unsigned S_W = ((P_W > OFS_W) ? P_W : OFS_W) + 2;
  localparam logic signed [S_W-1:0] MAX_S = S_W'((1 << COLOR_W) - 1);

  logic signed [S_W-1:0] sum;

  always_comb begin
    sum    = {{(S_W - P_W){1'b0}}, p_i} + {{(S_W - OFS_W){ofs_i[OFS_W-1]}}, ofs_i};
    sum_o  = sum[COLOR_W-1:0];
    clip_o = 1'b0;
    if (sum[S_W-1]) begin
      sum_o  = '0;
      clip_o = 1'b1;
    end else if (sum > MAX_S) begin
      sum_o  = MAX_S[COLOR_W-1:0];
      clip_o = 1'b1;
    end
  end

endmodule

// File: rtl/color_adjust_pipe.sv
// Two-stage per-channel gain/offset/greyscale colour stage feeding the display write FIFO.
module color_adjust_pipe
  import color_pkg::*;
#(
  parameter int unsigned COORD_W   = DEF_COORD_W,
  parameter int unsigned COLOR_W   = DEF_COLOR_W,
  parameter int unsigned GAIN_W    = DEF_GAIN_W,
  parameter int unsigned GAIN_FRAC = DEF_GAIN_FRAC,
  parameter int unsigned OFS_W     = DEF_OFS_W
) (
  input  logic               clk_25,
  input  logic               reset,
  input  logic               valid,
  output logic               ready,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [COLOR_W-1:0] red_i,
  input  logic [COLOR_W-1:0] green_i,
  input  logic [COLOR_W-1:0] blue_i,
  input  logic [1:0]         mode_i,
  input  logic [GAIN_W-1:0]  gain_r_i,
  input  logic [GAIN_W-1:0]  gain_g_i,
  input  logic [GAIN_W-1:0]  gain_b_i,
  input  logic [OFS_W-1:0]   ofs_r_i,
  input  logic [OFS_W-1:0]   ofs_g_i,
  input  logic [OFS_W-1:0]   ofs_b_i,
  input  logic               wrfull,
  output logic               wrreq,
  output logic               wrclk_25,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic [COLOR_W-1:0] red_o,
  output logic [COLOR_W-1:0] green_o,
  output logic [COLOR_W-1:0] blue_o,
  output logic               clip_o
);

  localparam int unsigned PROD_W = COLOR_W + GAIN_W;
  localparam int unsigned P_W    = PROD_W - GAIN_FRAC;
  localparam int unsigned L_W    = COLOR_W + 10;

  logic en, s2_valid;

  assign en       = ~(s2_valid & wrfull);
  assign ready    = en;
  assign wrreq    = s2_valid & ~wrfull;
  assign wrclk_25 = clk_25;

  // Stage 1: product / luma selection and per-pixel offset selection.
  logic [PROD_W-1:0]  prod_r, prod_g, prod_b;
  logic [L_W-1:0]     luma;
  logic [P_W-1:0]     p_r_d, p_g_d, p_b_d;
  logic [OFS_W-1:0]   o_r_d, o_g_d, o_b_d;

  always_comb begin
    prod_r = PROD_W'(red_i) * PROD_W'(gain_r_i);
    prod_g = PROD_W'(green_i) * PROD_W'(gain_g_i);
    prod_b = PROD_W'(blue_i) * PROD_W'(gain_b_i);
    luma   = L_W'(LUMA_R) * L_W'(red_i) + L_W'(LUMA_G) * L_W'(green_i)
           + L_W'(LUMA_B) * L_W'(blue_i);
    p_r_d  = P_W'(red_i);
    p_g_d  = P_W'(green_i);
    p_b_d  = P_W'(blue_i);
    o_r_d  = '0;
    o_g_d  = '0;
    o_b_d  = '0;
    unique case (mode_e'(mode_i))
      MODE_BYPASS: ;
      MODE_OFFSET: begin
        o_r_d = ofs_r_i;
        o_g_d = ofs_g_i;
        o_b_d = ofs_b_i;
      end
      MODE_GAIN: begin
        p_r_d = prod_r[GAIN_FRAC +: P_W];
        p_g_d = prod_g[GAIN_FRAC +: P_W];
        p_b_d = prod_b[GAIN_FRAC +: P_W];
        o_r_d = ofs_r_i;
        o_g_d = ofs_g_i;
        o_b_d = ofs_b_i;
      end
      MODE_GREY: begin
        p_r_d = P_W'(luma[LUMA_SHIFT +: COLOR_W]);
        p_g_d = P_W'(luma[LUMA_SHIFT +: COLOR_W]);
        p_b_d = P_W'(luma[LUMA_SHIFT +: COLOR_W]);
        o_r_d = ofs_r_i;
        o_g_d = ofs_r_i;
        o_b_d = ofs_r_i;
      end
    endcase
  end

  logic               s1_valid;
  logic [COORD_W-1:0] s1_x, s1_y;
  logic [P_W-1:0]     s1_p_r, s1_p_g, s1_p_b;
  logic [OFS_W-1:0]   s1_o_r, s1_o_g, s1_o_b;

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_p_r   <= '0;
      s1_p_g   <= '0;
      s1_p_b   <= '0;
      s1_o_r   <= '0;
      s1_o_g   <= '0;
      s1_o_b   <= '0;
    end else if (en) begin
      s1_valid <= valid;
      if (valid) begin
        s1_x   <= x_i;
        s1_y   <= y_i;
        s1_p_r <= p_r_d;
        s1_p_g <= p_g_d;
        s1_p_b <= p_b_d;
        s1_o_r <= o_r_d;
        s1_o_g <= o_g_d;
        s1_o_b <= o_b_d;
      end
    end
  end

  // Stage 2: saturating offset add into the output registers.
  logic [COLOR_W-1:0] sat_r, sat_g, sat_b;
  logic               clip_r, clip_g, clip_b;

  color_sat_add #(.P_W(P_W), .OFS_W(OFS_W), .COLOR_W(COLOR_W)) u_sat_r (
    .p_i(s1_p_r), .ofs_i(s1_o_r), .sum_o(sat_r), .clip_o(clip_r)
  );
  color_sat_add #(.P_W(P_W), .OFS_W(OFS_W), .COLOR_W(COLOR_W)) u_sat_g (
    .p_i(s1_p_g), .ofs_i(s1_o_g), .sum_o(sat_g), .clip_o(clip_g)
  );
  color_sat_add #(.P_W(P_W), .OFS_W(OFS_W), .COLOR_W(COLOR_W)) u_sat_b (
    .p_i(s1_p_b), .ofs_i(s1_o_b), .sum_o(sat_b), .clip_o(clip_b)
  );

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      x_o      <= '0;
      y_o      <= '0;
      red_o    <= '0;
      green_o  <= '0;
      blue_o   <= '0;
      clip_o   <= 1'b0;
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        x_o     <= s1_x;
        y_o     <= s1_y;
        red_o   <= sat_r;
        green_o <= sat_g;
        blue_o  <= sat_b;
        clip_o  <= clip_r | clip_g | clip_b;
      end
    end
  end

endmodule

// File: tb/tb_color_adjust_pipe.sv
// Directed and random-bypass checks of color_adjust_pipe with hand-computed expectations.
module tb_color_adjust_pipe;

  logic       clk_25 = 1'b0;
  logic       reset = 1'b0;
  logic       valid = 1'b0;
  logic       ready;
  logic [9:0] x_i = '0, y_i = '0;
  logic [7:0] red_i = '0, green_i = '0, blue_i = '0;
  logic [1:0] mode_i = '0;
  logic [7:0] gain_r_i = '0, gain_g_i = '0, gain_b_i = '0;
  logic [8:0] ofs_r_i = '0, ofs_g_i = '0, ofs_b_i = '0;
  logic       wrfull = 1'b0;
  logic       wrreq, wrclk_25;
  logic [9:0] x_o, y_o;
  logic [7:0] red_o, green_o, blue_o;
  logic       clip_o;

  int n_checks = 0;
  int n_pass = 0;

  color_adjust_pipe dut (
    .clk_25(clk_25), .reset(reset), .valid(valid), .ready(ready),
    .x_i(x_i), .y_i(y_i), .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
    .mode_i(mode_i), .gain_r_i(gain_r_i), .gain_g_i(gain_g_i), .gain_b_i(gain_b_i),
    .ofs_r_i(ofs_r_i), .ofs_g_i(ofs_g_i), .ofs_b_i(ofs_b_i), .wrfull(wrfull),
    .wrreq(wrreq), .wrclk_25(wrclk_25), .x_o(x_o), .y_o(y_o),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o), .clip_o(clip_o)
  );

  always #20 clk_25 = ~clk_25;

  task automatic drive(input logic [1:0] m, input logic [9:0] x, input logic [9:0] y,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic [7:0] gr, input logic [7:0] gg, input logic [7:0] gb,
                       input logic [8:0] orr, input logic [8:0] og, input logic [8:0] ob);
    mode_i = m; x_i = x; y_i = y; red_i = r; green_i = g; blue_i = b;
    gain_r_i = gr; gain_g_i = gg; gain_b_i = gb;
    ofs_r_i = orr; ofs_g_i = og; ofs_b_i = ob;
  endtask

  // Present one pixel for one accept edge, then stop just after the edge where it reaches stage 2.
  task automatic one_pixel(input logic [1:0] m, input logic [9:0] x, input logic [9:0] y,
                           input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                           input logic [7:0] gr, input logic [7:0] gg, input logic [7:0] gb,
                           input logic [8:0] orr, input logic [8:0] og, input logic [8:0] ob);
    @(negedge clk_25);
    drive(m, x, y, r, g, b, gr, gg, gb, orr, og, ob);
    valid = 1'b1;
    @(negedge clk_25);
    valid = 1'b0;
    @(posedge clk_25);
    #1;
  endtask

  task automatic test_reset();
    #5;
    n_checks++;
    if ({wrreq, x_o, y_o, red_o, green_o, blue_o, clip_o} !== 46'd0) begin
      $display("FAIL reset_state: got %h want 0",
               {wrreq, x_o, y_o, red_o, green_o, blue_o, clip_o});
    end else n_pass++;
    n_checks++;
    if (wrclk_25 !== clk_25) $display("FAIL wrclk: got %b want %b", wrclk_25, clk_25);
    else n_pass++;
    @(negedge clk_25);
    reset = 1'b1;
    @(posedge clk_25);
    #1;
    n_checks++;
    if (ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", ready);
    else n_pass++;
  endtask

  task automatic test_offset();
    one_pixel(2'd1, 10'd10, 10'd20, 8'd100, 8'd240, 8'd0, 8'd16, 8'd16, 8'd16,
              9'd30, 9'd30, 9'd30);
    n_checks++;
    if ({wrreq, x_o, y_o, red_o, green_o, blue_o, clip_o} !==
        {1'b1, 10'd10, 10'd20, 8'd130, 8'd255, 8'd30, 1'b1})
      $display("FAIL offset_plus30: got %h want %h",
               {wrreq, x_o, y_o, red_o, green_o, blue_o, clip_o},
               {1'b1, 10'd10, 10'd20, 8'd130, 8'd255, 8'd30, 1'b1});
    else n_pass++;
    @(posedge clk_25);
    #1;
    n_checks++;
    if ({wrreq, red_o, clip_o} !== {1'b0, 8'd130, 1'b1})
      $display("FAIL offset_hold: got %h want %h", {wrreq, red_o, clip_o},
               {1'b0, 8'd130, 1'b1});
    else n_pass++;
    one_pixel(2'd1, 10'd3, 10'd4, 8'd20, 8'd60, 8'd200, 8'd0, 8'd0, 8'd0,
              -9'sd50, -9'sd50, -9'sd50);
    n_checks++;
    if ({wrreq, red_o, green_o, blue_o, clip_o} !== {1'b1, 8'd0, 8'd10, 8'd150, 1'b1})
      $display("FAIL offset_neg_clamp: got %h want %h",
               {wrreq, red_o, green_o, blue_o, clip_o}, {1'b1, 8'd0, 8'd10, 8'd150, 1'b1});
    else n_pass++;
  endtask

  task automatic test_gain();
    one_pixel(2'd2, 10'd5, 10'd6, 8'd200, 8'd101, 8'd50, 8'd32, 8'd8, 8'd16,
              -9'sd10, 9'd0, 9'd0);
    n_checks++;
    if ({wrreq, red_o, green_o, blue_o, clip_o} !== {1'b1, 8'd255, 8'd50, 8'd50, 1'b1})
      $display("FAIL gain_mixed: got %h want %h", {wrreq, red_o, green_o, blue_o, clip_o},
               {1'b1, 8'd255, 8'd50, 8'd50, 1'b1});
    else n_pass++;
    one_pixel(2'd2, 10'd7, 10'd8, 8'd255, 8'd16, 8'd0, 8'd255, 8'd255, 8'd255,
              9'd0, 9'd0, 9'd0);
    n_checks++;
    if ({red_o, green_o, blue_o, clip_o} !== {8'd255, 8'd255, 8'd0, 1'b1})
      $display("FAIL gain_max: got %h want %h", {red_o, green_o, blue_o, clip_o},
               {8'd255, 8'd255, 8'd0, 1'b1});
    else n_pass++;
    one_pixel(2'd2, 10'd9, 10'd1, 8'd100, 8'd10, 8'd0, 8'd24, 8'd24, 8'd24,
              9'd0, 9'd0, 9'd0);
    n_checks++;
    if ({red_o, green_o, blue_o, clip_o} !== {8'd150, 8'd15, 8'd0, 1'b0})
      $display("FAIL gain_1p5: got %h want %h", {red_o, green_o, blue_o, clip_o},
               {8'd150, 8'd15, 8'd0, 1'b0});
    else n_pass++;
  endtask

  task automatic test_grey();
    one_pixel(2'd3, 10'd1, 10'd2, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0,
              9'd0, 9'd50, 9'd50);
    n_checks++;
    if ({red_o, green_o, blue_o, clip_o} !== {8'd255, 8'd255, 8'd255, 1'b0})
      $display("FAIL grey_white: got %h want %h", {red_o, green_o, blue_o, clip_o},
               {8'd255, 8'd255, 8'd255, 1'b0});
    else n_pass++;
    one_pixel(2'd3, 10'd1, 10'd2, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
              9'd0, 9'd0, 9'd0);
    n_checks++;
    if ({red_o, green_o, blue_o, clip_o} !== {8'd30, 8'd30, 8'd30, 1'b0})
      $display("FAIL grey_red100: got %h want %h", {red_o, green_o, blue_o, clip_o},
               {8'd30, 8'd30, 8'd30, 1'b0});
    else n_pass++;
    one_pixel(2'd3, 10'd1, 10'd2, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
              9'd5, -9'sd100, 9'd90);
    n_checks++;
    if ({red_o, green_o, blue_o, clip_o} !== {8'd35, 8'd35, 8'd35, 1'b0})
      $display("FAIL grey_ofs_r: got %h want %h", {red_o, green_o, blue_o, clip_o},
               {8'd35, 8'd35, 8'd35, 1'b0});
    else n_pass++;
  endtask

  // Eight back-to-back pixels; wrfull high in cycles 3..7 while stage 2 is occupied.
  task automatic test_back_to_back();
    int sent = 0;
    int writes = 0;
    int first_w = -1;
    int last_w = -1;
    @(posedge clk_25);
    @(posedge clk_25);
    for (int c = 0; c < 18; c++) begin
      @(negedge clk_25);
      wrfull = (c >= 3 && c <= 7);
      valid  = (sent < 8);
      drive(2'd0, 10'(sent + 1), 10'(sent + 100), 8'(sent * 10), 8'(sent), 8'(255 - sent),
            8'd0, 8'd0, 8'd0, 9'd0, 9'd0, 9'd0);
      #1;
      n_checks++;
      if (ready !== !(c >= 3 && c <= 7)) $display("FAIL b2b_ready c=%0d: got %b", c, ready);
      else n_pass++;
      if (wrreq) begin
        n_checks++;
        if (x_o !== 10'(writes + 1))
          $display("FAIL b2b_order: got x=%0d want %0d", x_o, writes + 1);
        else n_pass++;
        if (first_w < 0) first_w = c;
        last_w = c;
        writes++;
      end
      if (valid && ready) sent++;
    end
    valid  = 1'b0;
    wrfull = 1'b0;
    n_checks++;
    if (writes !== 8) $display("FAIL b2b_count: got %0d want 8", writes);
    else n_pass++;
    n_checks++;
    if (last_w - first_w + 1 !== 13) $display("FAIL b2b_span: got %0d want 13",
                                              last_w - first_w + 1);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    logic ghost = 1'b0;
    @(negedge clk_25);
    drive(2'd1, 10'd77, 10'd88, 8'd10, 8'd20, 8'd30, 8'd0, 8'd0, 8'd0, 9'd5, 9'd5, 9'd5);
    valid = 1'b1;
    @(negedge clk_25);
    x_i = 10'd78;
    @(negedge clk_25);
    valid  = 1'b0;
    wrfull = 1'b1;
    reset  = 1'b0;
    #1;
    n_checks++;
    if ({wrreq, x_o, y_o, red_o, green_o, blue_o, clip_o} !== 46'd0)
      $display("FAIL reset_midstream: got %h want 0",
               {wrreq, x_o, y_o, red_o, green_o, blue_o, clip_o});
    else n_pass++;
    wrfull = 1'b0;
    @(negedge clk_25);
    reset = 1'b1;
    @(posedge clk_25);
    #1;
    n_checks++;
    if (ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", ready);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_25);
      if (wrreq !== 1'b0) ghost = 1'b1;
    end
    n_checks++;
    if (ghost) $display("FAIL reset_ghost_write: got 1 want 0");
    else n_pass++;
  endtask

  task automatic test_bypass_random();
    logic [45:0] exp_q[$];
    logic [45:0] want;
    int sent = 0;
    int bad = 0;
    int cyc = 0;
    while ((sent < 1000 || exp_q.size() != 0) && cyc < 5000) begin
      @(negedge clk_25);
      cyc++;
      wrfull = ($urandom_range(0, 3) == 0);
      valid  = (sent < 1000);
      drive(2'd0, 10'($urandom), 10'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom),
            9'($urandom), 9'($urandom), 9'($urandom));
      #1;
      if (wrreq) begin
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 46'h3fff_ffff_ffff;
        n_checks++;
        if ({wrreq, x_o, y_o, red_o, green_o, blue_o, clip_o} !== want) begin
          bad++;
          if (bad < 5)
            $display("FAIL bypass_pixel: got %h want %h",
                     {wrreq, x_o, y_o, red_o, green_o, blue_o, clip_o}, want);
        end else n_pass++;
      end
      if (valid && ready) begin
        exp_q.push_back({1'b1, x_i, y_i, red_i, green_i, blue_i, 1'b0});
        sent++;
      end
    end
    valid  = 1'b0;
    wrfull = 1'b0;
    n_checks++;
    if (sent != 1000 || exp_q.size() != 0)
      $display("FAIL bypass_drain: got sent=%0d pending=%0d want 1000/0", sent, exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_offset();
    test_gain();
    test_grey();
    test_back_to_back();
    test_reset_midstream();
    test_bypass_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
